score_keeper: RTL

- Downstream consumer of the debounce stage in the basketball scoreboard.
- Takes the one-cycle debounced button pulses (S0 reset, S1/S2/S3 add 1/2/3 points) and the debounced possession switch levels (SW0 Team A, SW7 Team B).
- Maintains two 3-digit BCD team scores, stepped by a small add state machine, and feeds the display/scan stage.
- Runs on the same 100 Hz debounce clock, so each input pulse is exactly one cycle wide.

---
 rtl/score_keeper.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Two-team BCD score keeper fed by debounced button pulses and possession switches.
// Optional undo of the last accepted add is enabled with SCORE_UNDO_EN.
module score_keeper #(
    parameter logic [11:0] SAT_VALUE = 12'h999
) (
    input  logic        clk_db,
    input  logic        rst_n,
    input  logic        s0_p,
    input  logic        s1_p,
    input  logic        s2_p,
    input  logic        s3_p,
    input  logic        sw0_lvl,
    input  logic        sw7_lvl,
`ifdef SCORE_UNDO_EN
    input  logic        undo_p,
`endif
    output logic [11:0] score_a,
    output logic [11:0] score_b,
    output logic        poss_a,
    output logic        poss_b,
    output logic        poss_err,
    output logic        busy,
    output logic        last_team,
    output logic [1:0]  last_pts
);

    typedef enum logic {
        IDLE,
        ADD
    } state_t;

    state_t      state;
    logic [1:0]  rem;
    logic        tgt;
    logic        any_add;
    logic [1:0]  pts;
    logic [11:0] cur;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] h, t, o;
        {h, t, o} = v;
        if (o == 4'd9) begin
            o = 4'd0;
            if (t == 4'd9) begin
                t = 4'd0;
                h = (h == 4'd9) ? 4'd0 : h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            o = o + 4'd1;
        end
        return {h, t, o};
    endfunction

`ifdef SCORE_UNDO_EN
    // BCD ordering matches numeric ordering, so a plain compare finds the floor case
    function automatic logic [11:0] bcd_sub(input logic [11:0] v,
                                            input logic [1:0]  k);
        logic [3:0] h, t, o;
        logic [3:0] kk;
        kk = {2'b00, k};
        {h, t, o} = v;
        if (v < {8'd0, kk}) begin
            return 12'h000;
        end
        if (o >= kk) begin
            o = o - kk;
        end else begin
            o = o + 4'd10 - kk;
            if (t == 4'd0) begin
                t = 4'd9;
                h = h - 4'd1;
            end else begin
                t = t - 4'd1;
            end
        end
        return {h, t, o};
    endfunction
`endif

    always_comb begin
        any_add = s1_p | s2_p | s3_p;
        pts     = 2'd1;
        if (s3_p) begin
            pts = 2'd3;
        end else if (s2_p) begin
            pts = 2'd2;
        end
        cur = tgt ? score_b : score_a;
    end

    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= 2'd0;
            tgt       <= 1'b0;
            score_a   <= 12'h000;
            score_b   <= 12'h000;
            poss_a    <= 1'b0;
            poss_b    <= 1'b0;
            poss_err  <= 1'b0;
            busy      <= 1'b0;
            last_team <= 1'b0;
            last_pts  <= 2'd0;
        end else begin
            poss_a   <= sw0_lvl & ~sw7_lvl;
            poss_b   <= sw7_lvl & ~sw0_lvl;
            poss_err <= (sw0_lvl == sw7_lvl);
            case (state)
                IDLE: begin
                    if (s0_p) begin
                        score_a  <= 12'h000;
                        score_b  <= 12'h000;
                        last_pts <= 2'd0;
                    end else if (any_add && !poss_err) begin
                        tgt       <= poss_b;
                        rem       <= pts;
                        last_team <= poss_b;
                        last_pts  <= pts;
                        state     <= ADD;
                        busy      <= 1'b1;
                    end
`ifdef SCORE_UNDO_EN
                    else if (!any_add && undo_p && last_pts != 2'd0) begin
                        if (last_team) begin
                            score_b <= bcd_sub(score_b, last_pts);
                        end else begin
                            score_a <= bcd_sub(score_a, last_pts);
                        end
                        last_pts <= 2'd0;
                    end
`endif
                end
                ADD: begin
                    if (s0_p) begin
                        score_a  <= 12'h000;
                        score_b  <= 12'h000;
                        last_pts <= 2'd0;
                        rem      <= 2'd0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else if (cur == SAT_VALUE) begin
                        rem   <= 2'd0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (tgt) begin
                            score_b <= bcd_inc(cur);
                        end else begin
                            score_a <= bcd_inc(cur);
                        end
                        rem <= rem - 2'd1;
                        if (rem == 2'd1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
